weight_stream_feeder: RTL and testbench
=======================================

Name: weight_stream_feeder

Overview:
- Head-of-chain transmitter for a systolic row of weight-computation cells.
- Accepts whole input vectors on a valid/ready interface and buffers them in a small FIFO.
- Serialises each vector into the cells' (index, value, enable) stream, index 0..WEIGHT_AMOUNT-1, one element per clock, with no bubbles between consecutive vectors.
- Drives the chain's result bus head with a constant "no result" word, and guarantees the leading enable-low cycle the cells require.

Parameters:
- DATA_WIDTH, 8: width of a vector element and of the index bus.
- RESULT_WIDTH, 16: result bus is RESULT_WIDTH+1 bits; the MSB is the valid flag.
- WEIGHT_AMOUNT, 4: elements per vector; must be ≥2 and ≤ 2^DATA_WIDTH.
- FIFO_DEPTH, 4: number of buffered vectors; power of two, ≥2.
- COUNT_WIDTH, 16: width of the sent-vector counter.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  synchronous FIFO clear.
- in_data  in  DATA_WIDTH*WEIGHT_AMOUNT  vector; element i = in_data[DATA_WIDTH*i +: DATA_WIDTH].
- in_valid  in  1  vector offered.
- in_ready  out  1  vector accepted when in_valid && in_ready at an edge.
- out_index  out  DATA_WIDTH  element index to the first cell.
- out_value  out  DATA_WIDTH  element value to the first cell.
- out_result  out  RESULT_WIDTH+1  result bus head; always 0.
- out_enable  out  1  element valid.
- busy  out  1  FIFO non-empty or a vector is mid-stream.
- sent_count  out  COUNT_WIDTH  vectors fully emitted (index W-1 sent); wraps modulo 2^COUNT_WIDTH.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: out_index=0, out_value=0, out_result=0, out_enable=0, sent_count=0. The FIFO is empty and the state is LEAD.
- in_ready:
  - Combinational: in_ready = !rst && !flush && (count < FIFO_DEPTH).
  - A push is therefore impossible when the FIFO is full, during reset, or during flush.
- State machine:
  - LEAD: exactly one cycle after rst deasserts, with out_enable=0 regardless of FIFO contents; then go to IDLE.
  - IDLE: outputs idle (index/value/enable = 0). If count>0, pop the FIFO head into the working register, emit index 0 with element 0 and enable=1, and go to STREAM.
  - STREAM: emit index k+1 with element k+1 each edge.
    - When the emitted index is W-1, increment sent_count.
    - On the next edge, if count>0, pop and emit index 0 of the next vector (back-to-back, no gap). Otherwise return to IDLE with enable=0.
- Output timing: all outputs are registered. out_index/out_value are 0 whenever out_enable=0.
- Latency: a vector pushed at edge T into an empty FIFO while in IDLE has index 0 on the outputs after edge T+1. Index W-1 follows after edge T+W.
- Pop happens at the launch of index 0. The slot is freed at that edge, so in_ready may rise in the same cycle that element 0 is presented.
- Simultaneous push and pop: count is unchanged and data integrity is preserved.
- Order: vectors are emitted in FIFO order; pointers wrap modulo FIFO_DEPTH.
- flush:
  - Empties the FIFO at that edge.
  - A vector already in STREAM completes all W elements, so no partial vector reaches the cells.
  - A vector offered in the same cycle is not accepted.
- rst mid-stream:
  - Outputs go to reset values at that edge and the partial vector is abandoned.
  - This is harmless: the cells restart accumulation on index 0 and emit a result only on index W-1.
  - LEAD follows the release of rst.
- out_result is held at 0 so the first cell never sees a pass-through valid flag.
- busy = (count>0) || state==STREAM.

Decomposition:
- Package weight_stream_pkg:
  - State encoding (LEAD, IDLE, STREAM).
  - Index-width and pointer-width constants derived via $clog2.
- Sub-module weight_vector_fifo:
  - Synchronous FIFO of width DATA_WIDTH*WEIGHT_AMOUNT and depth FIFO_DEPTH.
  - Ports: push, pop, flush, head data, count, with synchronous reset.
- The top level holds the FSM, element index counter, working register, output registers and sent_count.

Test Plan:
1. Reset release, FIFO empty: hold rst for 3 cycles -> all outputs 0, in_ready=0 during rst. After release, out_enable=0 for ≥1 cycle; busy=0.
2. Single vector {8'd4,8'd3,8'd2,8'd1} pushed at edge T -> after T+1..T+4, (index,value) = (0,1),(1,2),(2,3),(3,4) with enable=1. Enable=0 after T+5; sent_count=1.
3. Three vectors pushed on consecutive cycles -> 12 consecutive enable=1 cycles, indices 0,1,2,3 repeating, values in push order; sent_count=3; busy falls after the last element.
4. Fill to FIFO_DEPTH=4 while a vector streams -> in_ready=0 when count=4. An offered fifth vector is held and accepted on the cycle the next pop frees a slot; no vector is lost or duplicated.
5. Assert flush during index 1 of vector A with B and C queued -> A completes through index 3; B and C are never emitted; sent_count increments by 1 only.
6. Assert rst during index 2 -> outputs 0 at the next edge, sent_count=0. After release, a new vector streams starting at index 0 following the LEAD cycle; a downstream cell model produces the correct dot product.

Source files
------------

// File: rtl/weight_stream_pkg.sv
// Shared types and width helpers for the weight stream feeder.
// Holds the FSM state encoding and the index/pointer width derivation.
package weight_stream_pkg;

  typedef enum logic [1:0] {
    ST_LEAD   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  // Never narrower than one bit, so a two-entry range still gets a real counter.
  function automatic int idx_bits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_WEIGHT_AMOUNT = 4;
  localparam int DEF_FIFO_DEPTH    = 4;
  localparam int DEF_IDX_W         = idx_bits(DEF_WEIGHT_AMOUNT);
  localparam int DEF_PTR_W         = idx_bits(DEF_FIFO_DEPTH);

endpackage

// File: rtl/weight_stream_feeder_if.sv
// Vector input handshake and cell-chain head bus of the weight stream feeder.
// The master side offers vectors and observes the stream; the slave side is the feeder.
interface weight_stream_feeder_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int RESULT_WIDTH  = 16,
  parameter int WEIGHT_AMOUNT = 4
);
  logic [DATA_WIDTH*WEIGHT_AMOUNT-1:0] in_data;
  logic                                in_valid;
  logic                                in_ready;
  logic [DATA_WIDTH-1:0]               out_index;
  logic [DATA_WIDTH-1:0]               out_value;
  logic [RESULT_WIDTH:0]               out_result;
  logic                                out_enable;

  modport master (
    output in_data, in_valid,
    input  in_ready, out_index, out_value, out_result, out_enable
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, out_index, out_value, out_result, out_enable
  );
endinterface

// File: rtl/weight_vector_fifo.sv
// Whole-vector synchronous FIFO; head data is valid the cycle after a push into an empty queue.
// No internal backpressure: the caller must not push when full nor pop when empty.
module weight_vector_fifo
  import weight_stream_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int PTR_W = idx_bits(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push && !rst && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap on natural overflow.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/weight_stream_feeder.sv
// Serialises buffered vectors into the (index, value, enable) cell stream; index 0 one cycle after accept.
// in_ready drops while the FIFO is full, in reset or in flush; consecutive vectors stream without bubbles.
module weight_stream_feeder
  import weight_stream_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int RESULT_WIDTH  = 16,
  parameter int WEIGHT_AMOUNT = 4,
  parameter int FIFO_DEPTH    = 4,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  weight_stream_feeder_if.slave  bus,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] sent_count
);

  localparam int VEC_W = DATA_WIDTH * WEIGHT_AMOUNT;
  localparam int IDX_W = idx_bits(WEIGHT_AMOUNT);
  localparam int CNT_W = idx_bits(FIFO_DEPTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WEIGHT_AMOUNT - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);

  state_t                  state_q, state_n;
  logic [IDX_W-1:0]        idx_q;
  logic [IDX_W-1:0]        idx_nxt;
  logic [VEC_W-1:0]        work_q;
  logic [VEC_W-1:0]        head_data;
  logic [CNT_W-1:0]        fifo_count;
  logic                    ready;
  logic                    push;
  logic                    avail;
  logic                    launch;
  logic                    advance;
  logic [DATA_WIDTH-1:0]   index_q;
  logic [DATA_WIDTH-1:0]   value_q;
  logic                    enable_q;

  assign ready   = !rst && !flush && (fifo_count < FULL_CNT);
  assign push    = bus.in_valid && ready;
  // A flush in the same cycle wipes the queued vector, so it must not be launched.
  assign avail   = (fifo_count != '0) && !flush;
  assign idx_nxt = idx_q + 1'b1;

  weight_vector_fifo #(
    .WIDTH (VEC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (bus.in_data),
    .pop       (launch),
    .head_data (head_data),
    .count     (fifo_count)
  );

  always_comb begin
    state_n = state_q;
    launch  = 1'b0;
    advance = 1'b0;
    case (state_q)
      ST_LEAD: begin
        state_n = ST_IDLE;
      end
      ST_IDLE: begin
        if (avail) begin
          launch  = 1'b1;
          state_n = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (idx_q != LAST_IDX) begin
          advance = 1'b1;
        end else if (avail) begin
          launch = 1'b1;
        end else begin
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_LEAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_LEAD;
      idx_q      <= '0;
      work_q     <= '0;
      index_q    <= '0;
      value_q    <= '0;
      enable_q   <= 1'b0;
      sent_count <= '0;
    end else begin
      state_q <= state_n;
      if (launch) begin
        work_q   <= head_data;
        idx_q    <= '0;
        index_q  <= '0;
        value_q  <= head_data[DATA_WIDTH-1:0];
        enable_q <= 1'b1;
      end else if (advance) begin
        idx_q    <= idx_nxt;
        index_q  <= DATA_WIDTH'(idx_nxt);
        value_q  <= work_q[idx_nxt*DATA_WIDTH +: DATA_WIDTH];
        enable_q <= 1'b1;
        if (idx_nxt == LAST_IDX) sent_count <= sent_count + 1'b1;
      end else begin
        index_q  <= '0;
        value_q  <= '0;
        enable_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = ready;
  assign bus.out_index  = index_q;
  assign bus.out_value  = value_q;
  assign bus.out_enable = enable_q;
  assign bus.out_result = {(RESULT_WIDTH + 1){1'b0}};
  assign busy           = (fifo_count != '0) || (state_q == ST_STREAM);

endmodule

// File: tb/tb_weight_stream_feeder.sv
// Directed bench for weight_stream_feeder: reset, streaming, backpressure, flush and mid-stream reset.
// A downstream cell model accumulates the stream against fixed weights to check the dot product.
module tb_weight_stream_feeder;

  localparam int DW = 8;
  localparam int RW = 16;
  localparam int W  = 4;
  localparam int FD = 4;
  localparam int CW = 16;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          flush = 1'b0;
  logic          busy;
  logic [CW-1:0] sent_count;

  int tests = 0;
  int fails = 0;

  weight_stream_feeder_if #(.DATA_WIDTH(DW), .RESULT_WIDTH(RW), .WEIGHT_AMOUNT(W)) bus ();

  weight_stream_feeder #(
    .DATA_WIDTH    (DW),
    .RESULT_WIDTH  (RW),
    .WEIGHT_AMOUNT (W),
    .FIFO_DEPTH    (FD),
    .COUNT_WIDTH   (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .bus        (bus),
    .busy       (busy),
    .sent_count (sent_count)
  );

  always #5 clk = ~clk;

  // First cell of the chain: restarts on index 0, reports on the last index.
  int cell_acc    = 0;
  int cell_result = -1;
  always @(negedge clk) begin
    int wt;
    case (bus.out_index)
      8'd0: wt = 2;
      8'd1: wt = 3;
      8'd2: wt = 5;
      default: wt = 7;
    endcase
    if (bus.out_enable) begin
      if (bus.out_index == 8'd0) cell_acc = int'(bus.out_value) * wt;
      else cell_acc = cell_acc + int'(bus.out_value) * wt;
      if (bus.out_index == 8'(W - 1)) cell_result = cell_acc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ev(input int id, input int i);
    return 8'(17 + 16 * id + i);
  endfunction

  function automatic logic [DW*W-1:0] mkvec(input int id);
    logic [DW*W-1:0] v;
    for (int i = 0; i < W; i++) v[DW*i +: DW] = ev(id, i);
    return v;
  endfunction

  function automatic logic [31:0] stream_word();
    return {15'd0, bus.out_enable, bus.out_index, bus.out_value};
  endfunction

  function automatic logic [31:0] elem_word(input int i, input logic [7:0] val);
    return {15'd0, 1'b1, 8'(i), val};
  endfunction

  // Offers nvec vectors back to back, checking in_ready each offer cycle and
  // every streamed element; in_ready is expected low only at cycle full_cycle.
  task automatic stream_burst(input int first_id, input int nvec, input int full_cycle);
    int  p = 0;
    logic acc;
    for (int n = 0; n <= nvec * W; n++) begin
      if (p < nvec) begin
        bus.in_valid = 1'b1;
        bus.in_data  = mkvec(first_id + p);
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (p < nvec) chk("burst_in_ready", {31'd0, bus.in_ready}, (n == full_cycle) ? 32'd0 : 32'd1);
      acc = bus.in_valid && bus.in_ready;
      step();
      if (acc) p++;
      if (n >= 1) chk("burst_elem", stream_word(), elem_word((n - 1) % W, ev(first_id + (n - 1) / W, (n - 1) % W)));
    end
    bus.in_valid = 1'b0;
    chk("burst_accepted", p, nvec);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // Reset held for three cycles.
    step(); step(); step();
    chk("rst_stream", stream_word(), 32'd0);
    chk("rst_result", {15'd0, bus.out_result}, 32'd0);
    chk("rst_sent", {16'd0, sent_count}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    rst = 1'b0;
    step();
    chk("lead_enable", stream_word(), 32'd0);
    chk("lead_busy", {31'd0, busy}, 32'd0);
    chk("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Single vector, elements 1,2,3,4.
    bus.in_data  = 32'h04030201;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("single_busy_queued", {31'd0, busy}, 32'd1);
    chk("single_pre", stream_word(), 32'd0);
    for (int k = 0; k < W; k++) begin
      step();
      chk("single_elem", stream_word(), elem_word(k, 8'(k + 1)));
    end
    step();
    chk("single_done", stream_word(), 32'd0);
    chk("single_sent", {16'd0, sent_count}, 32'd1);
    chk("single_busy_done", {31'd0, busy}, 32'd0);
    chk("single_dot", cell_result, 32'd51);

    // Three vectors on consecutive cycles stream without gaps.
    stream_burst(0, 3, -1);
    chk("three_busy_last", {31'd0, busy}, 32'd1);
    step();
    chk("three_done", stream_word(), 32'd0);
    chk("three_sent", {16'd0, sent_count}, 32'd4);
    chk("three_busy_done", {31'd0, busy}, 32'd0);

    // Six vectors: FIFO fills, the sixth waits one cycle for the next pop.
    stream_burst(3, 6, 5);
    step();
    chk("full_done", stream_word(), 32'd0);
    chk("full_sent", {16'd0, sent_count}, 32'd10);
    chk("full_busy_done", {31'd0, busy}, 32'd0);

    // Flush during index 1 of A while B and C are queued.
    bus.in_data  = mkvec(9);
    bus.in_valid = 1'b1;
    step();
    bus.in_data = mkvec(10);
    step();
    chk("flush_a0", stream_word(), elem_word(0, ev(9, 0)));
    bus.in_data = mkvec(11);
    step();
    chk("flush_a1", stream_word(), elem_word(1, ev(9, 1)));
    bus.in_data = mkvec(12);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", {31'd0, bus.in_ready}, 32'd0);
    step();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_a2", stream_word(), elem_word(2, ev(9, 2)));
    chk("flush_busy_stream", {31'd0, busy}, 32'd1);
    step();
    chk("flush_a3", stream_word(), elem_word(3, ev(9, 3)));
    step();
    chk("flush_no_b", stream_word(), 32'd0);
    chk("flush_sent", {16'd0, sent_count}, 32'd11);
    chk("flush_busy_done", {31'd0, busy}, 32'd0);
    step();
    chk("flush_no_c", stream_word(), 32'd0);

    // Reset while index 2 is on the outputs, then restream.
    bus.in_data  = mkvec(13);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    chk("rst_mid_e0", stream_word(), elem_word(0, ev(13, 0)));
    step();
    step();
    chk("rst_mid_e2", stream_word(), elem_word(2, ev(13, 2)));
    rst = 1'b1;
    #1;
    chk("rst_mid_in_ready", {31'd0, bus.in_ready}, 32'd0);
    step();
    chk("rst_mid_stream", stream_word(), 32'd0);
    chk("rst_mid_sent", {16'd0, sent_count}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    rst          = 1'b0;
    bus.in_data  = 32'h04030201;
    bus.in_valid = 1'b1;
    #1;
    chk("lead_in_ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    bus.in_valid = 1'b0;
    chk("relead_enable", stream_word(), 32'd0);
    for (int k = 0; k < W; k++) begin
      step();
      chk("restream_elem", stream_word(), elem_word(k, 8'(k + 1)));
    end
    step();
    chk("restream_done", stream_word(), 32'd0);
    chk("restream_sent", {16'd0, sent_count}, 32'd1);
    chk("restream_dot", cell_result, 32'd51);
    chk("restream_result", {15'd0, bus.out_result}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
